// File: rtl/conv_33.sv
// conv_33: streaming 3x3 convolution stage.
// The window is two registered columns (colA oldest, colB middle) plus the live
// input column. One of four fixed kernels is applied and the result is clamped
// to an unsigned pixel.
// Optional feature macro: CONV33_OUT_REG_EN (registers pixel_out, 1-cycle latency).
module conv_33 #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift_en,
    input  logic [PIXEL_WIDTH-1:0] pix_top,
    input  logic [PIXEL_WIDTH-1:0] pix_mid,
    input  logic [PIXEL_WIDTH-1:0] pix_bot,
    input  logic [1:0]             mode,
    output logic [PIXEL_WIDTH-1:0] pixel_out
);
    localparam int PW    = PIXEL_WIDTH;
    localparam int ACC_W = PW + 5;
    // Row index within a column
    localparam int T = 0;
    localparam int M = 1;
    localparam int B = 2;

    localparam logic signed [ACC_W-1:0] C_RND = ACC_W'(8);
    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((1 << PW) - 1);

    // Window state: colA is the oldest column, colB the centre column
    logic [2:0][PW-1:0] r_col_a;
    logic [2:0][PW-1:0] r_col_b;
    logic [2:0][PW-1:0] w_col_c;

    logic signed [ACC_W-1:0] w_corner;
    logic signed [ACC_W-1:0] w_cross;
    logic signed [ACC_W-1:0] w_ctr;
    logic signed [ACC_W-1:0] w_sharp;
    logic signed [ACC_W-1:0] w_gsum;
    logic signed [ACC_W-1:0] w_edge;
    logic [PW-1:0]           w_result;

    function automatic logic signed [ACC_W-1:0] zx(input logic [PW-1:0] p);
        return $signed({{(ACC_W-PW){1'b0}}, p});
    endfunction

    function automatic logic [PW-1:0] clamp(input logic signed [ACC_W-1:0] v);
        logic [PW-1:0] res;
        if (v < 0)
            res = '0;
        else if (v > C_MAX)
            res = C_MAX[PW-1:0];
        else
            res = v[PW-1:0];
        return res;
    endfunction

    assign w_col_c[T] = pix_top;
    assign w_col_c[M] = pix_mid;
    assign w_col_c[B] = pix_bot;

    // Shift the live column into the window; reset clears both columns at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_a <= '0;
            r_col_b <= '0;
        end else if (shift_en) begin
            r_col_a <= r_col_b;
            r_col_b <= w_col_c;
        end
    end

    // All kernels are symmetric: split the window into corner, cross and centre sums
    always_comb begin
        w_corner = zx(r_col_a[T]) + zx(r_col_a[B]) + zx(w_col_c[T]) + zx(w_col_c[B]);
        w_cross  = zx(r_col_a[M]) + zx(r_col_b[T]) + zx(r_col_b[B]) + zx(w_col_c[M]);
        w_ctr    = zx(r_col_b[M]);
        w_sharp  = (w_ctr <<< 2) + w_ctr - w_cross;
        w_gsum   = w_corner + (w_cross <<< 1) + (w_ctr <<< 2) + C_RND;
        w_edge   = (w_ctr <<< 3) - w_corner - w_cross;
    end

    // Kernel select; gaussian goes through clamp too, which never trips
    // because the rounded, normalised sum tops out at the pixel maximum
    always_comb begin
        w_result = r_col_b[M];
        case (mode)
            2'd0:    w_result = r_col_b[M];
            2'd1:    w_result = clamp(w_sharp);
            2'd2:    w_result = clamp(w_gsum >>> 4);
            default: w_result = clamp(w_edge);
        endcase
    end

`ifdef CONV33_OUT_REG_EN
    logic [PW-1:0] r_out;

    // Output register runs every edge, independent of shift_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_out <= '0;
        else
            r_out <= w_result;
    end

    assign pixel_out = r_out;
`else
    assign pixel_out = w_result;
`endif

endmodule

// File: tb/tb_conv_33.sv
// tb_conv_33: scoreboard bench for conv_33 (combinational or registered output build).
module tb_conv_33;
    localparam int PW = 8;
    localparam int WIDTH = 252;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          shift_en = 1'b0;
    logic [PW-1:0] pix_top = '0;
    logic [PW-1:0] pix_mid = '0;
    logic [PW-1:0] pix_bot = '0;
    logic [1:0]    mode = 2'd0;
    logic [PW-1:0] pixel_out;

    int n_cmp = 0;
    int n_bad = 0;

    int    exp_q[$];
    string tag_q[$];

    // Software window: index 0=top, 1=mid, 2=bot
    int mA[3];
    int mB[3];

    int rows[3][WIDTH];

    conv_33 #(.PIXEL_WIDTH(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .pix_top   (pix_top),
        .pix_mid   (pix_mid),
        .pix_bot   (pix_bot),
        .mode      (mode),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Generic 3x3 reference: weight table times window, then normalise/clamp
    function automatic int model(input int md, input int lt, input int lm, input int lb);
        int w[3][3];
        int k[3][3];
        int s;
        for (int r = 0; r < 3; r++) begin
            w[r][0] = mA[r];
            w[r][1] = mB[r];
        end
        w[0][2] = lt;
        w[1][2] = lm;
        w[2][2] = lb;
        case (md)
            1:       k = '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}};
            2:       k = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
            3:       k = '{'{-1, -1, -1}, '{-1, 8, -1}, '{-1, -1, -1}};
            default: k = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
        endcase
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += k[r][c] * w[r][c];
        if (md == 2) s = (s + 8) / 16;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Present one column, score the output for it (if ck), then optionally shift.
    // ex < 0 means take the expected value from the software model.
    task automatic step(input string tag, input int t, input int m, input int b,
                        input int md, input bit sh, input bit ck, input int ex);
        int e;
        @(negedge clk);
        pix_top  = PW'(t);
        pix_mid  = PW'(m);
        pix_bot  = PW'(b);
        mode     = md[1:0];
        shift_en = sh;
        e = (ex < 0) ? model(md, t, m, b) : ex;
        if (ck) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
`ifdef CONV33_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        if (ck) begin
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else chk(tag_q.pop_front(), pixel_out, exp_q.pop_front());
        end
        if (sh) begin
            mA = mB;
            mB[0] = t;
            mB[1] = m;
            mB[2] = b;
        end
    endtask

    // Async reset between edges, held across an edge with shift_en=1 (reset must win)
    task automatic do_reset();
        @(negedge clk);
        shift_en = 1'b1;
        pix_top = 8'd77;
        pix_mid = 8'd77;
        pix_bot = 8'd77;
        mode = 2'd0;
        #2 rst = 1'b1;
        #1 chk("rst_async_m0", pixel_out, 0);
        @(posedge clk);
        #1 chk("rst_hold_m0", pixel_out, 0);
        @(negedge clk);
        rst = 1'b0;
        shift_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mA[i] = 0;
            mB[i] = 0;
        end
    endtask

    initial begin
        int v;
        for (int i = 0; i < 3; i++) begin
            mA[i] = 0;
            mB[i] = 0;
        end

        // Reset state and reset-wins-over-shift
        do_reset();
        step("rst_wins_m0", 0, 0, 0, 0, 1'b0, 1'b1, 0);

        // Flat field
        do_reset();
        step("flat_ld", 100, 100, 100, 0, 1'b1, 1'b0, 0);
        step("flat_ld", 100, 100, 100, 0, 1'b1, 1'b0, 0);
        step("flat_m0", 100, 100, 100, 0, 1'b0, 1'b1, 100);
        step("flat_m1", 100, 100, 100, 1, 1'b0, 1'b1, 100);
        step("flat_m2", 100, 100, 100, 2, 1'b0, 1'b1, 100);
        step("flat_m3", 100, 100, 100, 3, 1'b0, 1'b1, 0);

        // Sharpen clamp high and low, edge clamp low
        do_reset();
        step("shp_ld", 0, 0, 0, 0, 1'b1, 1'b0, 0);
        step("shp_ld", 0, 255, 0, 0, 1'b1, 1'b0, 0);
        step("shp_hi", 0, 0, 0, 1, 1'b0, 1'b1, 255);
        do_reset();
        step("shp_ld", 255, 255, 255, 0, 1'b1, 1'b0, 0);
        step("shp_ld", 255, 0, 255, 0, 1'b1, 1'b0, 0);
        step("shp_lo", 255, 255, 255, 1, 1'b0, 1'b1, 0);
        step("edg_lo255", 255, 255, 255, 3, 1'b0, 1'b1, 0);

        // Edge
        do_reset();
        step("edg_ld", 0, 0, 0, 0, 1'b1, 1'b0, 0);
        step("edg_ld", 0, 10, 0, 0, 1'b1, 1'b0, 0);
        step("edg_pos", 0, 0, 0, 3, 1'b0, 1'b1, 80);
        do_reset();
        step("edg_ld", 10, 10, 10, 0, 1'b1, 1'b0, 0);
        step("edg_ld", 10, 0, 10, 0, 1'b1, 1'b0, 0);
        step("edg_neg", 10, 10, 10, 3, 1'b0, 1'b1, 0);

        // Gaussian rounding and full-scale
        do_reset();
        step("gau_ld", 0, 0, 0, 0, 1'b1, 1'b0, 0);
        step("gau_ld", 0, 16, 0, 0, 1'b1, 1'b0, 0);
        step("gau_rnd", 0, 0, 0, 2, 1'b0, 1'b1, 4);
        do_reset();
        step("gau_ld", 255, 255, 255, 0, 1'b1, 1'b0, 0);
        step("gau_ld", 255, 255, 255, 0, 1'b1, 1'b0, 0);
        step("gau_max", 255, 255, 255, 2, 1'b0, 1'b1, 255);

        // Hold for 5 cycles, then async reset mid-cycle
        do_reset();
        step("hold_ld", 12, 200, 34, 0, 1'b1, 1'b0, 0);
        step("hold_ld", 56, 78, 90, 0, 1'b1, 1'b0, 0);
        v = model(2, 9, 140, 60);
        for (int i = 0; i < 5; i++)
            step("hold_m2", 9, 140, 60, 2, 1'b0, 1'b1, v);
        step("hold_m0", 9, 140, 60, 0, 1'b0, 1'b1, 78);
        do_reset();
        step("post_rst_m0", 9, 140, 60, 0, 1'b0, 1'b1, 0);

        // Streamed 3-row image, one pass per mode, reset at row end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < WIDTH; c++)
                rows[r][c] = int'($urandom_range(0, 255));
        for (int md = 0; md < 4; md++) begin
            do_reset();
            for (int c = 0; c < WIDTH; c++)
                step($sformatf("row_m%0d_c%0d", md, c), rows[0][c], rows[1][c], rows[2][c],
                     md, 1'b1, (c >= 2), -1);
        end

        // Streamed row with the mode changing every column
        do_reset();
        for (int c = 0; c < WIDTH; c++)
            step($sformatf("mix_c%0d", c), rows[2][c], rows[0][c], rows[1][c],
                 c % 4, 1'b1, (c >= 2), -1);

        chk("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
